fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised successor to the two-stage ALU/comparator forwarding logic.
- Tracks the destination registers of in-flight instructions in an internal shadow pipeline of NUM_STAGES entries, so the pipeline no longer supplies a destination per stage.
- Drives forwarded operands for NUM_SRC source ports of the EX stage.
- Detects load-use hazards and inserts a one-cycle bubble through a small FSM. Sits between ID/EX and the EX-stage operand muxes.

Parameters:
- XLEN, 32, data width.
- NUM_STAGES, 3, tracked stages after EX; stage 0 = EX/MEM (youngest), stage NUM_STAGES-1 = oldest. Legal range 2..6.
- NUM_SRC, 3, source operand ports (rs1, rs2, store-data).
- REG_AW, 5, register index width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- hold  in  1  global pipeline freeze (cache miss); all state holds
- flush  in  1  branch/jump flush; kills tracked entries
- ex_rd  in  REG_AW  destination of the instruction in EX
- ex_rd_we  in  1  EX instruction writes regfile
- ex_is_load  in  1  EX instruction is a load
- ex_rs  in  NUM_SRC*REG_AW  source indices, port i at [i*REG_AW +: REG_AW]
- ex_rs_used  in  NUM_SRC  source i is actually read
- rf_data  in  NUM_SRC*XLEN  regfile read values
- stage_data  in  NUM_STAGES*XLEN  result held in tracked stage k
- mem_rdata  in  XLEN  load data returned for stage 1
- fwd_data  out  NUM_SRC*XLEN  operand value for source i
- fwd_hit  out  NUM_SRC  source i was forwarded
- fwd_stage  out  NUM_SRC*3  stage index used when the hit is set, else 0
- stall  out  1  hold IF/ID/EX this cycle; bubble enters stage 0

Behaviour:
- Shadow pipeline: per stage {valid, rd, is_load}.
  - Each clk with hold=0, entry k moves to k+1 and the oldest entry is dropped.
  - Stage 0 loads {ex_rd_we & (ex_rd!=0), ex_rd, ex_is_load} when stall=0, otherwise a bubble (valid=0).
  - hold=1 freezes all entries and the FSM; hold has priority over stall.
- Flush: valid of every entry with index >= 0 is cleared on the same edge, and the FSM returns to RUN. flush and hold together: flush wins.
- Reset: all valid=0, FSM=RUN.
  - Outputs after reset: stall=0, fwd_hit=0, fwd_stage=0, fwd_data=rf_data.
- Match for source i at stage k: ex_rs_used[i] & valid[k] & (rd[k]==ex_rs[i]) & (ex_rs[i]!=0).
  - x0 is never forwarded; an x0 operand yields rf_data, which is 0.
- Priority: the youngest (lowest k) matching stage wins.
- Data selection:
  - k=0: stage_data[0].
  - k=1 with is_load: mem_rdata.
  - Otherwise: stage_data[k].
- Load-use: a winning match at k=0 with is_load[0]=1 is a hazard. The fwd_data value in that cycle is don't-care and is not relied upon.
- FSM, combinational stall, registered state:
  - RUN: hazard & !hold drives stall=1. Next state is BUBBLE.
  - BUBBLE: stall=0. The load has moved to stage 1 and is forwarded from mem_rdata. Next state is RUN, or BUBBLE again if a new hazard exists.
  - The state only changes when hold=0.
- Back-to-back: a hazard is re-evaluated every cycle, so consecutive dependent loads each cost exactly one bubble.
- All forwarding outputs are purely combinational from the current state and inputs. There is zero latency apart from the one-cycle load-use bubble.

Optional Feature:
- Macro: FWD_HAZARD_PERF_EN.
- Defined:
  - Adds outputs perf_fwd_cnt (32) and perf_stall_cnt (32), both reset to 0.
  - perf_fwd_cnt increments by popcount(fwd_hit) on each cycle with hold=0 and stall=0.
  - perf_stall_cnt increments by 1 on each cycle with stall=1 and hold=0.
  - Both counters wrap modulo 2^32.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package (rv32i_types or new fwd_pkg):
  - Shadow entry struct {valid, rd, is_load}.
  - FSM enum {RUN, BUBBLE}.
  - Constant FWD_STAGE_W = 3.
- Sub-module fwd_match_sel: one instance per source, generate loop.
  - Performs the priority match across stages and the data selection.
  - Outputs hit, stage and hazard.

Test Plan:
1. Dependent ALU chain:
   - Stimulus: add x5 then sub x6,x5,x1, with stage_data[0]=0x11.
   - Required: fwd_hit[0]=1, fwd_stage=0, fwd_data[0]=0x11, stall=0.
2. Priority:
   - Stimulus: x7 valid in stage 0 (0xAA) and stage 2 (0xBB), source x7.
   - Required: fwd_data=0xAA.
3. Load-use:
   - Stimulus: lw x3, then add x4,x3,x3.
   - Required: stall=1 for exactly one cycle. Next cycle, with mem_rdata=0xDEADBEEF, both sources read 0xDEADBEEF with fwd_stage=1.
4. x0 and unused sources:
   - Stimulus: rd=0 with we=1; source x0, rf_data=0. Also ex_rs_used[1]=0 with a matching rd.
   - Required: no hit on either source.
5. Hold and flush:
   - Stimulus: hold=1 for 4 cycles during BUBBLE.
   - Required: state and entries frozen, stall=0.
   - Stimulus: flush=1.
   - Required: next cycle all fwd_hit=0, fwd_data=rf_data.
6. Async reset:
   - Stimulus: rst asserted mid-stall, between clock edges.
   - Required: stall drops immediately and all valid bits are 0. With FWD_HAZARD_PERF_EN defined, the counters read 0.

Source files
------------

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types for the EX-stage forwarding/hazard unit: shadow pipeline entry,
// bubble FSM encoding and the forwarded-stage index width.
package fwd_hazard_unit_pkg;

    localparam int FWD_STAGE_W = 3;
    // Wide enough for any REG_AW in use; narrower indices are zero-extended.
    localparam int SHADOW_RD_W = 8;

    typedef struct packed {
        logic                   valid;
        logic [SHADOW_RD_W-1:0] rd;
        logic                   is_load;
    } shadow_t;

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Bundle between ID/EX control, the EX operand muxes and fwd_hazard_unit.
// FWD_HAZARD_PERF_EN adds the two performance counter outputs.
interface fwd_hazard_unit_if #(
    parameter int XLEN       = 32,
    parameter int NUM_STAGES = 3,
    parameter int NUM_SRC    = 3,
    parameter int REG_AW     = 5
);
    import fwd_hazard_unit_pkg::*;

    logic                               hold;
    logic                               flush;
    logic [REG_AW-1:0]                  ex_rd;
    logic                               ex_rd_we;
    logic                               ex_is_load;
    logic [NUM_SRC*REG_AW-1:0]          ex_rs;
    logic [NUM_SRC-1:0]                 ex_rs_used;
    logic [NUM_SRC*XLEN-1:0]            rf_data;
    logic [NUM_STAGES*XLEN-1:0]         stage_data;
    logic [XLEN-1:0]                    mem_rdata;
    logic [NUM_SRC*XLEN-1:0]            fwd_data;
    logic [NUM_SRC-1:0]                 fwd_hit;
    logic [NUM_SRC*FWD_STAGE_W-1:0]     fwd_stage;
    logic                               stall;
`ifdef FWD_HAZARD_PERF_EN
    logic [31:0]                        perf_fwd_cnt;
    logic [31:0]                        perf_stall_cnt;
`endif

    modport master (
        output hold, flush, ex_rd, ex_rd_we, ex_is_load, ex_rs, ex_rs_used,
               rf_data, stage_data, mem_rdata,
`ifdef FWD_HAZARD_PERF_EN
        input  perf_fwd_cnt, perf_stall_cnt,
`endif
        input  fwd_data, fwd_hit, fwd_stage, stall
    );

    modport slave (
        input  hold, flush, ex_rd, ex_rd_we, ex_is_load, ex_rs, ex_rs_used,
               rf_data, stage_data, mem_rdata,
`ifdef FWD_HAZARD_PERF_EN
        output perf_fwd_cnt, perf_stall_cnt,
`endif
        output fwd_data, fwd_hit, fwd_stage, stall
    );

endinterface

// File: rtl/fwd_hazard_unit_match_sel.sv
// Per-source priority match across the shadow stages plus operand selection.
// Purely combinational; flags a load-use hazard when the winner is a load in stage 0.
module fwd_match_sel
    import fwd_hazard_unit_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NUM_STAGES = 3,
    parameter int REG_AW     = 5
) (
    input  logic [REG_AW-1:0]            rs,
    input  logic                         rs_used,
    input  logic [XLEN-1:0]              rf_data,
    input  shadow_t [NUM_STAGES-1:0]     entries,
    input  logic [NUM_STAGES*XLEN-1:0]   stage_data,
    input  logic [XLEN-1:0]              mem_rdata,
    output logic [XLEN-1:0]              data,
    output logic                         hit,
    output logic [FWD_STAGE_W-1:0]       stage,
    output logic                         hazard
);

    always_comb begin
        data   = rf_data;
        hit    = 1'b0;
        stage  = '0;
        hazard = 1'b0;
        // Oldest to youngest so the youngest match overwrites everything older.
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (rs_used && (rs != '0) && entries[k].valid &&
                (entries[k].rd == SHADOW_RD_W'(rs))) begin
                hit   = 1'b1;
                stage = FWD_STAGE_W'(k);
                if ((k == 1) && entries[k].is_load)
                    data = mem_rdata;
                else
                    data = stage_data[k*XLEN +: XLEN];
            end
        end
        hazard = hit && (stage == '0) && entries[0].is_load;
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding for the EX stage with an internal destination shadow pipeline.
// Zero-latency forwarding; a load-use dependency costs one stall/bubble cycle. FWD_HAZARD_PERF_EN adds counters.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NUM_STAGES = 3,
    parameter int NUM_SRC    = 3,
    parameter int REG_AW     = 5
) (
    input  logic               clk,
    input  logic               rst,
    fwd_hazard_unit_if.slave   bus
);

    shadow_t [NUM_STAGES-1:0]       shadow_q;
    shadow_t                        ex_entry;
    fsm_state_t                     state_q;
    fsm_state_t                     state_nxt;
    logic [NUM_SRC-1:0]             src_hazard;
    logic                           hazard;
    logic                           stall;
    logic [NUM_SRC*XLEN-1:0]        fwd_data;
    logic [NUM_SRC-1:0]             fwd_hit;
    logic [NUM_SRC*FWD_STAGE_W-1:0] fwd_stage;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_match_sel #(
            .XLEN       (XLEN),
            .NUM_STAGES (NUM_STAGES),
            .REG_AW     (REG_AW)
        ) u_match_sel (
            .rs         (bus.ex_rs[i*REG_AW +: REG_AW]),
            .rs_used    (bus.ex_rs_used[i]),
            .rf_data    (bus.rf_data[i*XLEN +: XLEN]),
            .entries    (shadow_q),
            .stage_data (bus.stage_data),
            .mem_rdata  (bus.mem_rdata),
            .data       (fwd_data[i*XLEN +: XLEN]),
            .hit        (fwd_hit[i]),
            .stage      (fwd_stage[i*FWD_STAGE_W +: FWD_STAGE_W]),
            .hazard     (src_hazard[i])
        );
    end

    assign hazard        = |src_hazard;
    assign bus.fwd_data  = fwd_data;
    assign bus.fwd_hit   = fwd_hit;
    assign bus.fwd_stage = fwd_stage;
    assign bus.stall     = stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= RUN;
        else
            state_q <= state_nxt;
    end

    // RUN and BUBBLE share the same exit rule: a fresh hazard leads to BUBBLE.
    always_comb begin
        state_nxt = state_q;
        if (bus.flush)
            state_nxt = RUN;
        else if (!bus.hold)
            state_nxt = hazard ? BUBBLE : RUN;
    end

    always_comb begin
        stall = 1'b0;
        case (state_q)
            RUN:     stall = hazard && !bus.hold;
            BUBBLE:  stall = 1'b0;
            default: stall = 1'b0;
        endcase
    end

    always_comb begin
        ex_entry         = '0;
        ex_entry.valid   = bus.ex_rd_we && (bus.ex_rd != '0);
        ex_entry.rd      = SHADOW_RD_W'(bus.ex_rd);
        ex_entry.is_load = bus.ex_is_load;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
        end else if (bus.flush) begin
            for (int k = 0; k < NUM_STAGES; k++)
                shadow_q[k].valid <= 1'b0;
        end else if (!bus.hold) begin
            for (int k = NUM_STAGES - 1; k > 0; k--)
                shadow_q[k] <= shadow_q[k-1];
            shadow_q[0] <= stall ? shadow_t'('0) : ex_entry;
        end
    end

`ifdef FWD_HAZARD_PERF_EN
    logic [31:0] perf_fwd_q;
    logic [31:0] perf_stall_q;
    logic [31:0] hit_cnt;

    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < NUM_SRC; i++)
            hit_cnt = hit_cnt + 32'(fwd_hit[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fwd_q   <= '0;
            perf_stall_q <= '0;
        end else if (!bus.hold) begin
            if (stall)
                perf_stall_q <= perf_stall_q + 32'd1;
            else
                perf_fwd_q <= perf_fwd_q + hit_cnt;
        end
    end

    assign bus.perf_fwd_cnt   = perf_fwd_q;
    assign bus.perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed plan scenarios followed by random traffic, all checked against a
// behavioural shadow-pipeline model kept in plain arrays.
module tb_fwd_hazard_unit;

    localparam int XLEN = 32;
    localparam int NS   = 3;
    localparam int NSRC = 3;
    localparam int AW   = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.XLEN(XLEN), .NUM_STAGES(NS), .NUM_SRC(NSRC), .REG_AW(AW)) bus ();

    fwd_hazard_unit #(.XLEN(XLEN), .NUM_STAGES(NS), .NUM_SRC(NSRC), .REG_AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Model: instructions in flight (youngest first) and "previous cycle was a stall".
    bit          m_valid [NS];
    int          m_rd    [NS];
    bit          m_ld    [NS];
    bit          m_bub;
    bit          m_any;
    logic [31:0] m_pfwd;
    logic [31:0] m_pstall;
    bit          e_hit   [NSRC];
    int          e_stage [NSRC];
    logic [31:0] e_data  [NSRC];
    bit          e_haz   [NSRC];
    bit          e_stall;

    task automatic model_reset();
        for (int k = 0; k < NS; k++) begin
            m_valid[k] = 0;
            m_rd[k]    = 0;
            m_ld[k]    = 0;
        end
        m_bub    = 0;
        m_pfwd   = '0;
        m_pstall = '0;
    endtask

    task automatic model_eval();
        int rs;
        m_any = 0;
        for (int i = 0; i < NSRC; i++) begin
            rs         = int'(bus.ex_rs[i*AW +: AW]);
            e_hit[i]   = 0;
            e_stage[i] = 0;
            e_haz[i]   = 0;
            e_data[i]  = bus.rf_data[i*XLEN +: XLEN];
            if (bus.ex_rs_used[i] && rs != 0) begin
                for (int k = 0; k < NS; k++) begin
                    if (!e_hit[i] && m_valid[k] && m_rd[k] == rs) begin
                        e_hit[i]   = 1;
                        e_stage[i] = k;
                        e_data[i]  = (k == 1 && m_ld[1]) ? bus.mem_rdata
                                                          : bus.stage_data[k*XLEN +: XLEN];
                        e_haz[i]   = (k == 0 && m_ld[0]);
                    end
                end
            end
            m_any |= e_haz[i];
        end
        e_stall = !m_bub && m_any && !bus.hold;
    endtask

    task automatic check_outputs(input string tag);
        model_eval();
        chk({tag, ".stall"}, 32'(bus.stall), 32'(e_stall));
        for (int i = 0; i < NSRC; i++) begin
            chk($sformatf("%s.hit%0d", tag, i), 32'(bus.fwd_hit[i]), 32'(e_hit[i]));
            chk($sformatf("%s.stage%0d", tag, i), 32'(bus.fwd_stage[i*3 +: 3]), 32'(e_stage[i]));
            if (!e_haz[i])
                chk($sformatf("%s.data%0d", tag, i), bus.fwd_data[i*XLEN +: XLEN], e_data[i]);
        end
`ifdef FWD_HAZARD_PERF_EN
        chk({tag, ".perf_fwd"}, bus.perf_fwd_cnt, m_pfwd);
        chk({tag, ".perf_stall"}, bus.perf_stall_cnt, m_pstall);
`endif
    endtask

    // Advance one clock; inputs are stable from the previous negedge through the posedge.
    task automatic tick();
        int hits;
        model_eval();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (!bus.hold) begin
                hits = 0;
                for (int i = 0; i < NSRC; i++) hits += int'(e_hit[i]);
                if (e_stall) m_pstall = m_pstall + 32'd1;
                else         m_pfwd   = m_pfwd + 32'(hits);
            end
            if (bus.flush) begin
                for (int k = 0; k < NS; k++) m_valid[k] = 0;
                m_bub = 0;
            end else if (!bus.hold) begin
                for (int k = NS - 1; k > 0; k--) begin
                    m_valid[k] = m_valid[k-1];
                    m_rd[k]    = m_rd[k-1];
                    m_ld[k]    = m_ld[k-1];
                end
                m_valid[0] = !e_stall && bus.ex_rd_we && (bus.ex_rd != '0);
                m_rd[0]    = int'(bus.ex_rd);
                m_ld[0]    = bus.ex_is_load;
                m_bub      = m_bub ? m_any : e_stall;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_ex(input int rd, input bit we, input bit ld,
                          input int rs0, input int rs1, input int rs2, input logic [2:0] used);
        bus.ex_rd      = AW'(rd);
        bus.ex_rd_we   = we;
        bus.ex_is_load = ld;
        bus.ex_rs      = {AW'(rs2), AW'(rs1), AW'(rs0)};
        bus.ex_rs_used = used;
    endtask

    initial begin
        rst            = 1'b1;
        bus.hold       = 1'b0;
        bus.flush      = 1'b0;
        bus.mem_rdata  = 32'h0;
        bus.rf_data    = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        bus.stage_data = {32'h0000_00BB, 32'h0000_0055, 32'h0000_00AA};
        set_ex(0, 0, 0, 1, 2, 3, 3'b111);
        model_reset();
        #2;
        chk("reset.stall", 32'(bus.stall), 32'h0);
        chk("reset.hit", 32'(bus.fwd_hit), 32'h0);
        chk("reset.stage", 32'(bus.fwd_stage), 32'h0);
        chk("reset.data0", bus.fwd_data[31:0], 32'h1111_1111);
        chk("reset.data2", bus.fwd_data[95:64], 32'h3333_3333);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Dependent ALU chain: add x5 ; sub x6,x5,x1
        bus.stage_data[31:0] = 32'h11;
        set_ex(5, 1, 0, 0, 0, 0, 3'b000); tick();
        set_ex(6, 1, 0, 5, 1, 0, 3'b011); #1;
        chk("alu.hit0", 32'(bus.fwd_hit[0]), 32'h1);
        chk("alu.stage0", 32'(bus.fwd_stage[2:0]), 32'h0);
        chk("alu.data0", bus.fwd_data[31:0], 32'h11);
        chk("alu.stall", 32'(bus.stall), 32'h0);
        check_outputs("alu"); tick();

        // Priority: x7 in stage 2 and stage 0
        bus.stage_data = {32'h0000_00BB, 32'h0000_0055, 32'h0000_00AA};
        set_ex(7, 1, 0, 0, 0, 0, 3'b000); tick();
        set_ex(0, 0, 0, 0, 0, 0, 3'b000); tick();
        set_ex(7, 1, 0, 0, 0, 0, 3'b000); tick();
        set_ex(8, 1, 0, 7, 0, 0, 3'b001); #1;
        chk("prio.data0", bus.fwd_data[31:0], 32'hAA);
        chk("prio.stage0", 32'(bus.fwd_stage[2:0]), 32'h0);
        check_outputs("prio"); tick();

        // Load-use: lw x3 ; add x4,x3,x3
        set_ex(3, 1, 1, 0, 0, 0, 3'b000); tick();
        set_ex(4, 1, 0, 3, 3, 0, 3'b011); #1;
        chk("ldu.stall", 32'(bus.stall), 32'h1);
        check_outputs("ldu"); tick();
        bus.mem_rdata = 32'hDEAD_BEEF; #1;
        chk("ldu2.stall", 32'(bus.stall), 32'h0);
        chk("ldu2.data0", bus.fwd_data[31:0], 32'hDEAD_BEEF);
        chk("ldu2.data1", bus.fwd_data[63:32], 32'hDEAD_BEEF);
        chk("ldu2.stage0", 32'(bus.fwd_stage[2:0]), 32'h1);
        chk("ldu2.stage1", 32'(bus.fwd_stage[5:3]), 32'h1);
        check_outputs("ldu2"); tick();
        set_ex(10, 1, 0, 4, 0, 0, 3'b001); #1;
        chk("ldu3.stall", 32'(bus.stall), 32'h0);
        check_outputs("ldu3"); tick();

        // x0 destination/source and an unused source with a matching rd
        set_ex(9, 1, 0, 0, 0, 0, 3'b000); tick();
        set_ex(0, 1, 0, 0, 0, 0, 3'b000); tick();
        bus.rf_data[31:0] = 32'h0;
        set_ex(11, 0, 0, 0, 9, 0, 3'b001); #1;
        chk("x0.hit0", 32'(bus.fwd_hit[0]), 32'h0);
        chk("x0.hit1", 32'(bus.fwd_hit[1]), 32'h0);
        chk("x0.data0", bus.fwd_data[31:0], 32'h0);
        check_outputs("x0"); tick();

        // Hold during BUBBLE, then flush
        bus.rf_data[31:0] = 32'h1234_5678;
        set_ex(3, 1, 1, 0, 0, 0, 3'b000); tick();
        set_ex(4, 1, 0, 3, 0, 0, 3'b001); #1;
        chk("hold.pre_stall", 32'(bus.stall), 32'h1);
        tick();
        bus.hold = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("hold.stall", 32'(bus.stall), 32'h0);
            chk("hold.stage0", 32'(bus.fwd_stage[2:0]), 32'h1);
            chk("hold.data0", bus.fwd_data[31:0], 32'hDEAD_BEEF);
            check_outputs("hold"); tick();
        end
        bus.hold  = 1'b0;
        bus.flush = 1'b1; #1;
        check_outputs("flush"); tick();
        bus.flush = 1'b0; #1;
        chk("flush.hit", 32'(bus.fwd_hit), 32'h0);
        chk("flush.data0", bus.fwd_data[31:0], 32'h1234_5678);
        check_outputs("post_flush"); tick();

        // Asynchronous reset between edges while stalling
        set_ex(3, 1, 1, 0, 0, 0, 3'b000); tick();
        set_ex(4, 1, 0, 3, 3, 0, 3'b011); #1;
        chk("arst.pre_stall", 32'(bus.stall), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("arst.stall", 32'(bus.stall), 32'h0);
        chk("arst.hit", 32'(bus.fwd_hit), 32'h0);
`ifdef FWD_HAZARD_PERF_EN
        chk("arst.perf_fwd", bus.perf_fwd_cnt, 32'h0);
        chk("arst.perf_stall", bus.perf_stall_cnt, 32'h0);
`endif
        model_reset();
        @(negedge clk);
        rst = 1'b0; #1;
        check_outputs("arst.post"); tick();

        // Random traffic on a small register set to provoke matches and hazards
        for (int n = 0; n < 600; n++) begin
            bus.hold       = ($urandom_range(0, 9) == 0);
            bus.flush      = ($urandom_range(0, 19) == 0);
            bus.rf_data    = {$urandom, $urandom, $urandom};
            bus.stage_data = {$urandom, $urandom, $urandom};
            bus.mem_rdata  = $urandom;
            set_ex(int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   3'($urandom));
            #1;
            check_outputs("rnd");
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
